// File: rtl/pcie_cpl_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcie_cpl_gen : queues 2-DW memory read requests, reads 64 bits of local
//                register space and returns each as a 5-DW CplD TLP.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module pcie_cpl_gen #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_valid,
  input  logic [12:0] address,
  input  logic [23:0] rid_tag,
  input  logic [15:0] completer_id,
  output logic        rd_en,
  output logic [12:0] rd_addr,
  input  logic [63:0] rd_data,
  output logic        overflow,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast,
  output logic [7:0]  tkeep,
  output logic [63:0] tdata
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]  C_LAT    = 3'(READ_LATENCY);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_BEAT0 = 3'd2;
  localparam logic [2:0] S_BEAT1 = 3'd3;
  localparam logic [2:0] S_BEAT2 = 3'd4;

  logic [36:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [2:0]    state_q, state_d;
  logic [2:0]    lat_cnt_q;
  logic [12:0]   addr_q;
  logic [23:0]   rid_q;
  logic [63:0]   data_q;
  logic [15:0]   cid_q;
  logic          rd_en_q;
  logic [12:0]   rd_addr_q;
  logic          overflow_q;

  logic          w_empty, w_full, w_pop, w_push, w_hs;
  logic [36:0]   w_head;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == C_FULL);
  assign w_pop   = (state_q == S_IDLE) && !w_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push  = read_valid && (!w_full || w_pop);
  assign w_head  = mem_q[rd_ptr_q];
  assign w_hs    = tvalid && tready;

  always_ff @(posedge clock) begin
    if (w_push) mem_q[wr_ptr_q] <= {address, rid_tag};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (w_push && !w_pop)      count_q <= count_q + 1'b1;
      else if (!w_push && w_pop) count_q <= count_q - 1'b1;
      if (read_valid && !w_push) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!w_empty) state_d = S_READ;
      S_READ:  if (lat_cnt_q == 3'd0) state_d = S_BEAT0;
      S_BEAT0: if (w_hs) state_d = S_BEAT1;
      S_BEAT1: if (w_hs) state_d = S_BEAT2;
      S_BEAT2: if (w_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      rid_q     <= '0;
      data_q    <= '0;
      cid_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= w_pop;
      if (w_pop) begin
        rd_addr_q <= w_head[36:24];
        addr_q    <= w_head[36:24];
        rid_q     <= w_head[23:0];
        lat_cnt_q <= C_LAT;
      end
      if (state_q == S_READ) begin
        if (lat_cnt_q == 3'd0) begin
          data_q <= rd_data;
          cid_q  <= completer_id;
        end else begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  logic [31:0] w_dw0, w_dw1, w_dw2;
  assign w_dw0 = {1'b0, 7'b1001010, 14'd0, 10'd2};
  assign w_dw1 = {cid_q, 3'b000, 1'b0, 12'd8};
  assign w_dw2 = {rid_q, 1'b0, addr_q[3:0], 3'b000};

  always_comb begin
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = 8'h00;
    tdata  = 64'd0;
    case (state_q)
      S_BEAT0: begin
        tvalid = 1'b1;
        tkeep  = 8'hFF;
        tdata  = {w_dw1, w_dw0};
      end
      S_BEAT1: begin
        tvalid = 1'b1;
        tkeep  = 8'hFF;
        tdata  = {bswap(data_q[31:0]), w_dw2};
      end
      S_BEAT2: begin
        tvalid = 1'b1;
        tlast  = 1'b1;
        tkeep  = 8'h0F;
        tdata  = {32'd0, bswap(data_q[63:32])};
      end
      default: ;
    endcase
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_cpl_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pcie_cpl_gen : directed bench for the CplD completion generator.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_pcie_cpl_gen;

  localparam int C_LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_valid;
  logic [12:0] address;
  logic [23:0] rid_tag;
  logic [15:0] completer_id;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [63:0] rd_data;
  logic        overflow;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [7:0]  tkeep;
  logic [63:0] tdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] rd_q[$];
  logic [63:0] pipe0_q, pipe1_q;

  pcie_cpl_gen #(.FIFO_DEPTH(4), .READ_LATENCY(C_LAT)) u_dut (
    .clock(clock), .reset(reset), .read_valid(read_valid), .address(address),
    .rid_tag(rid_tag), .completer_id(completer_id), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .overflow(overflow),
    .tvalid(tvalid), .tready(tready), .tlast(tlast), .tkeep(tkeep),
    .tdata(tdata)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] mem(input logic [12:0] a);
    return 64'h1122334455667788 ^ {51'd0, a ^ 13'd5};
  endfunction

  // Register space model: data is valid exactly C_LAT cycles after rd_en.
  always @(posedge clock) begin
    pipe0_q <= (rd_en === 1'b1) ? mem(rd_addr) : 64'hDEADBEEFDEADBEEF;
    pipe1_q <= pipe0_q;
  end
  assign rd_data = pipe1_q;

  always @(negedge clock) if (rd_en === 1'b1) rd_q.push_back(rd_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [191:0] model(input logic [15:0] cid, input logic [12:0] a,
                                         input logic [23:0] rid, input logic [63:0] d);
    logic [63:0] b0, b1, b2;
    b0 = {cid, 3'b000, 1'b0, 12'd8, 1'b0, 7'b1001010, 14'd0, 10'd2};
    b1 = {bsw(d[31:0]), rid, 1'b0, a[3:0], 3'b000};
    b2 = {32'd0, bsw(d[63:32])};
    return {b2, b1, b0};
  endfunction

  // Called at a negedge; returns at the negedge after this beat's handshake.
  task automatic get_beat(input int stall, output logic [63:0] d,
                          output logic [7:0] k, output logic l);
    int n;
    n = 0;
    d = '0; k = '0; l = 1'b0;
    tready = (stall == 0);
    while (tvalid !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (tvalid !== 1'b1) begin
      chk("beat_timeout", {63'd0, tvalid}, 64'd1);
      return;
    end
    d = tdata; k = tkeep; l = tlast;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      chk("stall_tdata", tdata, d);
      chk("stall_ctrl", {54'd0, tvalid, tlast, tkeep}, {54'd0, 1'b1, l, k});
    end
    tready = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic get_tlp(input int stall, output logic [191:0] d, output logic [26:0] kl);
    logic [63:0] bd;
    logic [7:0]  bk[3];
    logic        bl[3];
    for (int i = 0; i < 3; i++) begin
      get_beat(stall, bd, bk[i], bl[i]);
      d[64*i +: 64] = bd;
    end
    kl = {bk[0], bk[1], bk[2], bl[0], bl[1], bl[2]};
  endtask

  task automatic check_tlp(input string tag, input logic [191:0] d,
                           input logic [26:0] kl, input logic [191:0] e);
    chk({tag, "_b0"}, d[63:0], e[63:0]);
    chk({tag, "_b1"}, d[127:64], e[127:64]);
    chk({tag, "_b2"}, d[191:128], e[191:128]);
    chk({tag, "_keep_last"}, {37'd0, kl}, {37'd0, 8'hFF, 8'hFF, 8'h0F, 3'b001});
  endtask

  task automatic strobe(input logic [12:0] a, input logic [23:0] rid);
    read_valid = 1'b1; address = a; rid_tag = rid;
    @(negedge clock);
    read_valid = 1'b0;
  endtask

  task automatic idle_watch(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tvalid !== 1'b0) seen++;
    end
  endtask

  localparam logic [191:0] C_S1 = {64'h00000000_44332211, 64'h88776655_ABCD1228,
                                   64'h01000008_4A000002};

  initial begin
    logic [191:0] d;
    logic [26:0]  kl;
    logic [63:0]  bd;
    logic [7:0]   bk;
    logic         bl;
    int           seen;

    reset = 1'b1; read_valid = 1'b0; address = '0; rid_tag = '0;
    completer_id = 16'h0100; tready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_tx", {tvalid, tlast, tkeep, tdata[53:0]}, 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_rd_ovf", {49'd0, rd_en, rd_addr, overflow}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single read, tready high
    rd_q.delete();
    strobe(13'h0005, 24'hABCD12);
    get_tlp(0, d, kl);
    check_tlp("s1", d, kl, C_S1);
    chk("s1_rd_cnt", 64'(rd_q.size()), 64'd1);
    if (rd_q.size() > 0) chk("s1_rd_addr", {51'd0, rd_q[0]}, 64'h5);

    // Same request with 5-cycle stalls on every beat
    strobe(13'h0005, 24'hABCD12);
    get_tlp(5, d, kl);
    check_tlp("s2", d, kl, C_S1);

    // Four back-to-back requests
    rd_q.delete();
    for (int i = 0; i < 4; i++) begin
      read_valid = 1'b1; address = 13'(i); rid_tag = 24'h300000 + 24'(i);
      @(negedge clock);
    end
    read_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      get_tlp(0, d, kl);
      check_tlp($sformatf("s3_%0d", i), d, kl,
                model(16'h0100, 13'(i), 24'h300000 + 24'(i), mem(13'(i))));
    end
    chk("s3_ovf", {63'd0, overflow}, 64'd0);

    // Six requests with tready low: the sixth is dropped
    rd_q.delete();
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      read_valid = 1'b1; address = 13'(8 + i); rid_tag = 24'h400000 + 24'(i);
      @(negedge clock);
    end
    read_valid = 1'b0;
    chk("s4_ovf", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      get_tlp(0, d, kl);
      check_tlp($sformatf("s4_%0d", i), d, kl,
                model(16'h0100, 13'(8 + i), 24'h400000 + 24'(i), mem(13'(8 + i))));
    end
    idle_watch(20, seen);
    chk("s4_no_sixth", 64'(seen), 64'd0);
    chk("s4_rd_cnt", 64'(rd_q.size()), 64'd5);

    // Reset during BEAT1 with a second request still queued
    read_valid = 1'b1; address = 13'h0021; rid_tag = 24'h500000;
    @(negedge clock);
    address = 13'h0022; rid_tag = 24'h500001;
    @(negedge clock);
    read_valid = 1'b0;
    get_beat(0, bd, bk, bl);
    tready = 1'b0;
    chk("s5_in_beat1", tdata, model(16'h0100, 13'h21, 24'h500000, mem(13'h21))[127:64]);
    #2 reset = 1'b1;
    #1;
    chk("s5_async", {61'd0, tvalid, tlast, overflow}, 64'd0);
    chk("s5_tdata", tdata, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    rd_q.delete();
    tready = 1'b1;
    idle_watch(20, seen);
    chk("s5_fifo_empty", {32'(seen), 32'(rd_q.size())}, 64'd0);
    completer_id = 16'hBEEF;
    strobe(13'h1FFA, 24'h123456);
    completer_id = 16'hBEEF;
    get_tlp(0, d, kl);
    check_tlp("s5_after", d, kl, model(16'hBEEF, 13'h1FFA, 24'h123456, mem(13'h1FFA)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
